// File: rtl/bitwise_op_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bitwise_op_checker                                                         |
// | Drives a deterministic a/b sequence into an external bitwise-op DUT, aligns |
// | the expected result to LATENCY and counts mismatches on y.                 |
// | Option: BITWISE_CHECKER_STOP_ON_FAIL_EN ends the run at the first mismatch.|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module bitwise_op_checker #(
    parameter int WIDTH    = 8,
    parameter int NUM_VECS = 16,
    parameter int LATENCY  = 0,
    parameter int OP       = 2,
    parameter int SEED_A   = 3,
    parameter int SEED_B   = 12
) (
    input  logic             clock,
    input  logic             reset,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] y,
    output logic [15:0]      err_count,
    output logic             fail,
    output logic             finish
);
    localparam int c_IDX_W = (NUM_VECS > 1) ? $clog2(NUM_VECS) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(NUM_VECS - 1);

    localparam logic [1:0] c_RUN   = 2'd0;
    localparam logic [1:0] c_DRAIN = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [c_IDX_W-1:0] r_idx;
    logic [15:0]        r_err;
    logic               r_fail;
    logic [WIDTH-1:0]   w_exp;
    logic               w_chk_v;
    logic [WIDTH-1:0]   w_chk_exp;
    logic               w_drain_last;
    logic               w_mismatch;
    logic               w_stop;
    logic               w_run;
    logic               w_done;

    always_comb begin
        case (OP)
            0:       w_exp = r_a & r_b;
            1:       w_exp = r_a | r_b;
            default: w_exp = r_a ^ r_b;
        endcase
    end

    generate
        if (LATENCY == 0) begin : g_comb_check
            assign w_chk_v      = w_run;
            assign w_chk_exp    = w_exp;
            assign w_drain_last = 1'b1;
        end else begin : g_delay_line
            localparam logic [LATENCY-1:0] c_TOP = LATENCY'(1) << (LATENCY - 1);
            logic [LATENCY-1:0] r_dl_v;
            logic [WIDTH-1:0]   r_dl_exp [LATENCY];

            always_ff @(posedge clock) begin
                if (reset) begin
                    r_dl_v <= '0;
                end else begin
                    r_dl_v[0] <= w_run;
                    for (int i = 1; i < LATENCY; i++) r_dl_v[i] <= r_dl_v[i-1];
                end
            end

            // Data slots need no reset: they are only ever read behind their valid bit.
            always_ff @(posedge clock) begin
                r_dl_exp[0] <= w_run ? w_exp : '0;
                for (int i = 1; i < LATENCY; i++) r_dl_exp[i] <= r_dl_exp[i-1];
            end

            assign w_chk_v      = r_dl_v[LATENCY-1] && !w_done;
            assign w_chk_exp    = r_dl_exp[LATENCY-1];
            assign w_drain_last = ((r_dl_v & ~c_TOP) == '0);
        end
    endgenerate

    assign w_mismatch = w_chk_v && (y != w_chk_exp);

`ifdef BITWISE_CHECKER_STOP_ON_FAIL_EN
    assign w_stop = w_mismatch;
`else
    assign w_stop = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) r_state <= c_RUN;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_RUN: begin
                if (w_stop)
                    w_state_next = c_DONE;
                else if (r_idx == c_LAST)
                    w_state_next = (LATENCY == 0) ? c_DONE : c_DRAIN;
            end
            c_DRAIN: begin
                if (w_stop || w_drain_last) w_state_next = c_DONE;
            end
            default: w_state_next = c_DONE;
        endcase
    end

    always_comb begin
        w_run  = (r_state == c_RUN);
        w_done = (r_state == c_DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_a    <= WIDTH'(SEED_A);
            r_b    <= WIDTH'(SEED_B);
            r_idx  <= '0;
            r_err  <= '0;
            r_fail <= 1'b0;
        end else begin
            // Operands advance only while another vector remains to be issued.
            if (w_run && (w_state_next == c_RUN)) begin
                r_a   <= r_a + WIDTH'(1);
                r_b   <= r_b - WIDTH'(3);
                r_idx <= r_idx + c_IDX_W'(1);
            end
            if (w_mismatch) begin
                r_fail <= 1'b1;
                if (r_err != 16'hFFFF) r_err <= r_err + 16'd1;
            end
        end
    end

    assign a         = r_a;
    assign b         = r_b;
    assign err_count = r_err;
    assign fail      = r_fail;
    assign finish    = w_done;

endmodule
`default_nettype wire

// File: tb/tb_bitwise_op_checker.sv
`default_nettype none
// Bench for bitwise_op_checker: several configurations run side by side, each
// against a modelled external DUT with randomized fault injection.
module tb_bitwise_op_checker;
    localparam int NCFG = 9;
    // cfg:                          0  1  2  3  4   5     6      7   8
    localparam int CFG_W   [NCFG] = '{8, 8, 8, 8, 4, 8, 8,     16, 5};
    localparam int CFG_N   [NCFG] = '{1, 4, 8, 8, 4, 16, 70000, 20, 12};
    localparam int CFG_L   [NCFG] = '{0, 0, 2, 1, 0, 0, 0,     3,  1};
    localparam int CFG_D   [NCFG] = '{0, 0, 2, 2, 0, 0, 0,     3,  1};
    localparam int CFG_OP  [NCFG] = '{2, 2, 2, 2, 0, 2, 2,     1,  5};
    localparam int CFG_SA  [NCFG] = '{3, 3, 3, 3, 14, 3, 3,    100, 30};
    localparam int CFG_SB  [NCFG] = '{12, 12, 12, 12, 1, 12, 12, 7, 2};
    // fault mode: 0 none, 1 random sparse flips, 2 always inverted, 3 bit0 flip when a==5
    localparam int CFG_M   [NCFG] = '{0, 3, 1, 0, 0, 2, 2,     1,  1};

    localparam int K_A = 0, K_B = 1, K_FIN = 2, K_ERR = 3, K_FAIL = 4;

    typedef struct {
        int     inst;
        int     t;
        int     kind;
        longint val;
    } lit_t;

    logic            clk;
    logic [NCFG-1:0] rst_v;
    int              n_checks = 0;
    int              n_errs   = 0;
    lit_t            lits[$];

    wire [31:0]     mon_t    [NCFG];
    wire [63:0]     mon_a    [NCFG];
    wire [63:0]     mon_b    [NCFG];
    wire [63:0]     mon_err  [NCFG];
    wire [NCFG-1:0] mon_fin;
    wire [NCFG-1:0] mon_fail;
    wire [NCFG-1:0] mon_live;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic longint ref_op(int op, longint x, longint z);
        case (op)
            0:       return x & z;
            1:       return x | z;
            default: return x ^ z;
        endcase
    endfunction

    task automatic chk(input string nm, input int inst, input int tt,
                       input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errs++;
            $display("FAIL %s cfg%0d t=%0d: got %0d, expected %0d", nm, inst, tt, act, expv);
        end
    endtask

    task automatic add(input int inst, input int t, input int kind, input longint val);
        lit_t l;
        l.inst = inst; l.t = t; l.kind = kind; l.val = val;
        lits.push_back(l);
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int W    = CFG_W[g];
        localparam int N    = CFG_N[g];
        localparam int L    = CFG_L[g];
        localparam int D    = CFG_D[g];
        localparam int OPV  = CFG_OP[g];
        localparam int SA   = CFG_SA[g];
        localparam int SB   = CFG_SB[g];
        localparam int MODE = CFG_M[g];

        logic [W-1:0] a_s, b_s, y_s, comb_s;
        logic [15:0]  err_s;
        logic         fail_s, fin_s;
        int           t;
        bit           live;
        logic [31:0]  flip_mem [64];
        logic [31:0]  flipv;

        bitwise_op_checker #(
            .WIDTH(W), .NUM_VECS(N), .LATENCY(L), .OP(OPV), .SEED_A(SA), .SEED_B(SB)
        ) u_dut (
            .clock(clk), .reset(rst_v[g]), .a(a_s), .b(b_s), .y(y_s),
            .err_count(err_s), .fail(fail_s), .finish(fin_s)
        );

        initial begin
            for (int j = 0; j < 64; j++)
                flip_mem[j] = ($urandom_range(0, 3) == 0) ? ($urandom | 32'd1) : 32'd0;
        end

        // t counts cycles from the cycle following the most recent reset edge.
        always_ff @(posedge clk) begin
            if (rst_v[g]) begin
                t    <= 0;
                live <= 1'b1;
            end else begin
                t <= t + 1;
            end
        end

        // External DUT: the reference op plus an injected fault, D registers deep.
        always_comb begin
            case (MODE)
                1:       flipv = flip_mem[t % 64];
                2:       flipv = 32'hFFFF_FFFF;
                3:       flipv = (a_s == W'(5)) ? 32'd1 : 32'd0;
                default: flipv = 32'd0;
            endcase
            comb_s = W'(ref_op(OPV, longint'(a_s), longint'(b_s)) ^ longint'(flipv));
        end

        if (D == 0) begin : g_comb_dut
            assign y_s = comb_s;
        end else begin : g_pipe_dut
            logic [W-1:0] stg [D];
            always_ff @(posedge clk) begin
                if (rst_v[g]) begin
                    for (int j = 0; j < D; j++) stg[j] <= '0;
                end else begin
                    stg[0] <= comb_s;
                    for (int j = 1; j < D; j++) stg[j] <= stg[j-1];
                end
            end
            assign y_s = stg[D-1];
        end

        assign mon_t[g]    = t;
        assign mon_a[g]    = 64'(a_s);
        assign mon_b[g]    = 64'(b_s);
        assign mon_err[g]  = 64'(err_s);
        assign mon_fin[g]  = fin_s;
        assign mon_fail[g] = fail_s;
        assign mon_live[g] = live;

        // Reference model: vector k is (SA+k, SB-3k) mod 2^W, checked at cycle k+L.
        initial begin : p_model
            longint mask, err_m, idx, ea, eb, ye;
            int     tdone, k;
            mask  = (64'd1 << W) - 1;
            err_m = 0;
            tdone = N + L;
            forever begin
                @(negedge clk);
                if (live) begin
                    if (t == 0) begin
                        err_m = 0;
                        tdone = N + L;
                    end
                    idx = t;
                    if (idx > tdone - 1) idx = tdone - 1;
                    if (idx > N - 1)     idx = N - 1;
                    ea = (SA + idx) & mask;
                    eb = (SB - 3 * idx) & mask;
                    chk("a", g, t, 64'(a_s), ea);
                    chk("b", g, t, 64'(b_s), eb);
                    chk("finish", g, t, 64'(fin_s), (t >= tdone) ? 1 : 0);
                    if (t >= tdone) begin
                        chk("err_count", g, t, 64'(err_s), err_m);
                        chk("fail", g, t, 64'(fail_s), (err_m != 0) ? 1 : 0);
                    end
                    k = t - L;
                    if (t < tdone && k >= 0 && k < N) begin
                        ye = ref_op(OPV, (SA + k) & mask, (SB - 3 * k) & mask) & mask;
                        if (longint'(y_s) != ye) begin
                            if (err_m < 65535) err_m = err_m + 1;
`ifdef BITWISE_CHECKER_STOP_ON_FAIL_EN
                            tdone = t + 1;
`endif
                        end
                    end
                end
            end
        end
    end

    // Hand-computed expectations that pin the model.
    initial begin
        add(0, 0, K_FIN, 0); add(0, 1, K_FIN, 1); add(0, 1, K_ERR, 0); add(0, 1, K_FAIL, 0);
        add(4, 0, K_A, 14); add(4, 1, K_A, 15); add(4, 2, K_A, 0); add(4, 3, K_A, 1);
        add(4, 0, K_B, 1);  add(4, 1, K_B, 14); add(4, 2, K_B, 11); add(4, 3, K_B, 8);
        add(4, 4, K_FIN, 1); add(4, 4, K_ERR, 0);
        add(3, 9, K_FIN, 1); add(3, 9, K_FAIL, 1);
        add(5, 0, K_A, 3);  add(5, 0, K_ERR, 0);
`ifdef BITWISE_CHECKER_STOP_ON_FAIL_EN
        add(1, 2, K_FIN, 0); add(1, 3, K_FIN, 1); add(1, 3, K_ERR, 1); add(1, 3, K_FAIL, 1);
        add(6, 1, K_FIN, 1); add(6, 1, K_ERR, 1);
`else
        add(1, 3, K_FIN, 0); add(1, 4, K_FIN, 1); add(1, 4, K_ERR, 1); add(1, 4, K_FAIL, 1);
        add(2, 9, K_FIN, 0); add(2, 10, K_FIN, 1);
        add(5, 16, K_FIN, 1); add(5, 16, K_ERR, 16);
        add(6, 69999, K_FIN, 0); add(6, 70000, K_FIN, 1);
        add(6, 70000, K_ERR, 65535); add(6, 70000, K_FAIL, 1);
`endif
        forever begin
            @(negedge clk);
            foreach (lits[j]) begin
                if (mon_live[lits[j].inst] && mon_t[lits[j].inst] == 32'(lits[j].t)) begin
                    case (lits[j].kind)
                        K_A:     chk("lit_a", lits[j].inst, lits[j].t, mon_a[lits[j].inst], lits[j].val);
                        K_B:     chk("lit_b", lits[j].inst, lits[j].t, mon_b[lits[j].inst], lits[j].val);
                        K_FIN:   chk("lit_finish", lits[j].inst, lits[j].t, 64'(mon_fin[lits[j].inst]), lits[j].val);
                        K_ERR:   chk("lit_err", lits[j].inst, lits[j].t, mon_err[lits[j].inst], lits[j].val);
                        default: chk("lit_fail", lits[j].inst, lits[j].t, 64'(mon_fail[lits[j].inst]), lits[j].val);
                    endcase
                end
            end
        end
    end

    initial begin : p_main
        bit seen;
        bit all_done;
        rst_v = '1;
        repeat (3) @(negedge clk);
        rst_v = '0;

        // One-cycle reset pulse on cfg 5 during its cycle 6.
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (mon_t[5] == 32'd6) seen = 1'b1;
        end
        chk("reset_pulse_reached", 5, 6, 64'(seen), 1);
        rst_v[5] = 1'b1;
        @(negedge clk);
        rst_v[5] = 1'b0;

        all_done = 1'b0;
        for (int c = 0; c < 80000 && !all_done; c++) begin
            @(negedge clk);
            if (&mon_fin) all_done = 1'b1;
        end
        chk("all_finished", 0, 0, 64'(all_done), 1);
        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
